// File: rtl/dt_est_pkg.sv
// Shared constants and helpers for the dT EMA estimator.
package dt_est_pkg;

  // Unity weight for the 8-bit alpha: new = (old*(ALPHA_ONE-alpha) + x*alpha) / ALPHA_ONE
  localparam int ALPHA_ONE = 256;

  // Convert a signed fixed-point value with 'frac' fraction bits to an integer,
  // rounding toward zero (a plain arithmetic shift would round toward -inf).
  function automatic logic signed [31:0] trunc_q_to_int(input logic signed [31:0] q,
                                                        input int unsigned       frac);
    logic signed [31:0] mag_s;
    logic signed [31:0] res_s;
    if (q < 32'sd0) begin
      mag_s = -q;
      res_s = -(mag_s >>> frac);
    end else begin
      mag_s = q;
      res_s = mag_s >>> frac;
    end
    return res_s;
  endfunction

endpackage

// File: rtl/dt_ema_core.sv
// Combinational datapath for one sample: delta, scale by 2^-k, EMA blend,
// symmetric clamp and toward-zero conversion to the output format.
module dt_ema_core
  import dt_est_pkg::*;
#(
  parameter int W     = 8,
  parameter int FRAC  = 7,
  parameter int ACC_W = W + FRAC + 2
) (
  input  logic signed [W-1:0]     t_cur,
  input  logic signed [W-1:0]     t_prev,
  input  logic signed [ACC_W-1:0] acc,
  input  logic        [7:0]       alpha,
  input  logic        [3:0]       k_dt,
  input  logic        [W-2:0]     d_max,
  output logic signed [ACC_W-1:0] acc_next,
  output logic signed [W-1:0]     dt,
  output logic                    sat
);

  localparam int PW = ACC_W + 9;
  localparam logic [3:0] K_MAX = (FRAC > 15) ? 4'd15 : 4'(FRAC);

  logic signed [W:0]       delta_s;
  logic signed [ACC_W-1:0] delta_ext_s;
  logic signed [ACC_W-1:0] delta_q_s;
  logic signed [ACC_W-1:0] ds_s;
  logic        [3:0]       k_eff_s;
  logic        [8:0]       w_old_u;
  logic signed [PW-1:0]    acc_w_s;
  logic signed [PW-1:0]    ds_w_s;
  logic signed [PW-1:0]    w_old_s;
  logic signed [PW-1:0]    w_new_s;
  logic signed [PW-1:0]    sum_s;
  logic signed [ACC_W-1:0] acc_raw_s;
  logic signed [ACC_W-1:0] lim_s;
  logic signed [ACC_W-1:0] neg_lim_s;
  logic signed [31:0]      acc_q32_s;

  // The difference of two W-bit samples always fits in W+1 bits.
  assign delta_s     = {t_cur[W-1], t_cur} - {t_prev[W-1], t_prev};
  assign delta_ext_s = {{(ACC_W-W-1){delta_s[W]}}, delta_s};
  assign k_eff_s     = (k_dt > K_MAX) ? K_MAX : k_dt;
  assign delta_q_s   = delta_ext_s <<< FRAC;
  assign ds_s        = delta_q_s >>> k_eff_s;

  assign w_old_u = 9'(ALPHA_ONE) - {1'b0, alpha};
  assign acc_w_s = {{9{acc[ACC_W-1]}}, acc};
  assign ds_w_s  = {{9{ds_s[ACC_W-1]}}, ds_s};
  assign w_old_s = {{(PW-9){1'b0}}, w_old_u};
  assign w_new_s = {{(PW-8){1'b0}}, alpha};
  assign sum_s   = (acc_w_s * w_old_s) + (ds_w_s * w_new_s);
  assign acc_raw_s = ACC_W'(sum_s >>> 8);

  assign lim_s     = {{(ACC_W-FRAC-(W-1)){1'b0}}, d_max, {FRAC{1'b0}}};
  assign neg_lim_s = -lim_s;

  // Symmetric clamp of the blended accumulator; flag when the value was changed.
  always_comb begin
    acc_next = acc_raw_s;
    sat      = 1'b0;
    if (acc_raw_s > lim_s) begin
      acc_next = lim_s;
      sat      = 1'b1;
    end else if (acc_raw_s < neg_lim_s) begin
      acc_next = neg_lim_s;
      sat      = 1'b1;
    end else begin
      acc_next = acc_raw_s;
      sat      = 1'b0;
    end
  end

  assign acc_q32_s = {{(32-ACC_W){acc_next[ACC_W-1]}}, acc_next};
  assign dt        = W'(trunc_q_to_int(acc_q32_s, FRAC));

endmodule

// File: rtl/dt_estimator_mc.sv
// Multi-channel EMA estimator of dT with saturation, valid/ready in and out.
// Optional build macro DT_EST_SAT_CNT_EN adds per-channel 16-bit clamp-event
// counters readable through sat_sel/sat_cnt; without it sat_cnt reads 16'h0.
module dt_estimator_mc
  import dt_est_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int W      = 8,
  parameter int FRAC   = 7,
  parameter int WARMUP = 2,
  parameter int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [CH_W-1:0]     s_ch,
  input  logic signed [W-1:0] s_T,
  input  logic [N_CH-1:0]     init_mask,
  input  logic [7:0]          alpha,
  input  logic [3:0]          k_dt,
  input  logic [W-2:0]        d_max,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [CH_W-1:0]     m_ch,
  output logic signed [W-1:0] m_dT,
  output logic                m_sat,
  output logic                m_warm,
  input  logic [CH_W-1:0]     sat_sel,
  output logic [15:0]         sat_cnt
);

  localparam int ACC_W = W + FRAC + 2;
  localparam logic [CH_W:0] N_CH_L   = (CH_W+1)'(N_CH);
  localparam logic [3:0]    WARMUP_L = 4'(WARMUP);

  typedef struct packed {
    logic signed [W-1:0]     t_prev;
    logic signed [ACC_W-1:0] acc;
    logic                    primed;
    logic [3:0]              warm_cnt;
  } dt_ch_state_t;

  dt_ch_state_t st_r [N_CH];
  dt_ch_state_t cur_s;

  logic                    ready_en_r;
  logic                    ch_ok_s;
  logic                    init_hit_s;
  logic                    fire_s;
  logic [3:0]              warm_inc_s;
  logic signed [ACC_W-1:0] core_acc_s;
  logic signed [W-1:0]     core_dt_s;
  logic                    core_sat_s;
  logic signed [W-1:0]     out_dt_s;
  logic                    out_sat_s;
  logic                    out_warm_s;

  assign ch_ok_s = ({1'b0, s_ch} < N_CH_L);
  assign s_ready = ready_en_r & (~m_valid | m_ready);
  assign fire_s  = s_valid & s_ready & ch_ok_s;

  // Fetch the addressed channel's state and its init pulse (none for out-of-range indices).
  always_comb begin
    cur_s      = '0;
    init_hit_s = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      if (s_ch == CH_W'(c)) begin
        cur_s      = st_r[c];
        init_hit_s = init_mask[c];
      end else begin
        cur_s      = cur_s;
        init_hit_s = init_hit_s;
      end
    end
  end

  assign warm_inc_s = (cur_s.warm_cnt >= WARMUP_L) ? cur_s.warm_cnt : (cur_s.warm_cnt + 4'd1);

  dt_ema_core #(
    .W     (W),
    .FRAC  (FRAC),
    .ACC_W (ACC_W)
  ) u_core (
    .t_cur    (s_T),
    .t_prev   (cur_s.t_prev),
    .acc      (cur_s.acc),
    .alpha    (alpha),
    .k_dt     (k_dt),
    .d_max    (d_max),
    .acc_next (core_acc_s),
    .dt       (core_dt_s),
    .sat      (core_sat_s)
  );

  // First sample after (re)init only captures T_prev, so its result is a neutral zero.
  always_comb begin
    out_dt_s   = '0;
    out_sat_s  = 1'b0;
    out_warm_s = 1'b0;
    if (init_hit_s || !cur_s.primed) begin
      out_dt_s   = '0;
      out_sat_s  = 1'b0;
      out_warm_s = 1'b0;
    end else begin
      out_dt_s   = core_dt_s;
      out_sat_s  = core_sat_s;
      out_warm_s = (warm_inc_s >= WARMUP_L);
    end
  end

  // Hold off input acceptance for one cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_r <= 1'b0;
    end else begin
      ready_en_r <= 1'b1;
    end
  end

  // Per-channel state: init pulses take priority over a same-cycle sample update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++) begin
        st_r[c] <= '0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (init_mask[c]) begin
          if (fire_s && (s_ch == CH_W'(c))) begin
            st_r[c].t_prev   <= s_T;
            st_r[c].acc      <= '0;
            st_r[c].primed   <= 1'b1;
            st_r[c].warm_cnt <= 4'd0;
          end else begin
            st_r[c].acc      <= '0;
            st_r[c].primed   <= 1'b0;
            st_r[c].warm_cnt <= 4'd0;
          end
        end else if (fire_s && (s_ch == CH_W'(c))) begin
          st_r[c].t_prev <= s_T;
          st_r[c].primed <= 1'b1;
          if (st_r[c].primed) begin
            st_r[c].acc      <= core_acc_s;
            st_r[c].warm_cnt <= warm_inc_s;
          end else begin
            st_r[c].acc      <= '0;
            st_r[c].warm_cnt <= 4'd0;
          end
        end
      end
    end
  end

  // Single output register: load on accept, clear when consumed, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_ch    <= '0;
      m_dT    <= '0;
      m_sat   <= 1'b0;
      m_warm  <= 1'b0;
    end else if (fire_s) begin
      m_valid <= 1'b1;
      m_ch    <= s_ch;
      m_dT    <= out_dt_s;
      m_sat   <= out_sat_s;
      m_warm  <= out_warm_s;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

`ifdef DT_EST_SAT_CNT_EN
  logic [15:0] sat_cnt_r [N_CH];

  // Count clamped results per channel, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++) begin
        sat_cnt_r[c] <= 16'h0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (fire_s && out_sat_s && (s_ch == CH_W'(c)) && (sat_cnt_r[c] != 16'hFFFF)) begin
          sat_cnt_r[c] <= sat_cnt_r[c] + 16'h1;
        end
      end
    end
  end

  // Combinational read-out of the selected channel's counter.
  always_comb begin
    sat_cnt = 16'h0;
    for (int c = 0; c < N_CH; c++) begin
      if (sat_sel == CH_W'(c)) begin
        sat_cnt = sat_cnt_r[c];
      end else begin
        sat_cnt = sat_cnt;
      end
    end
  end
`else
  logic sat_sel_unused_s;
  assign sat_sel_unused_s = ^sat_sel;
  assign sat_cnt          = 16'h0;
`endif

endmodule

// File: tb/tb_dt_estimator_mc.sv
// Self-checking bench for dt_estimator_mc: reference model + scoreboard queue,
// a separate monitor compares every presented result against the queue head.
module tb_dt_estimator_mc;

  localparam int N_CH = 4, W = 8, FRAC = 7, WARMUP = 2, CH_W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               s_valid, s_ready, m_valid, m_ready, m_sat, m_warm;
  logic [CH_W-1:0]    s_ch, m_ch, sat_sel;
  logic signed [W-1:0] s_T, m_dT;
  logic [N_CH-1:0]    init_mask;
  logic [7:0]         alpha;
  logic [3:0]         k_dt;
  logic [W-2:0]       d_max;
  logic [15:0]        sat_cnt;

  // Second, 3-channel instance used only to exercise out-of-range channel indices.
  logic               s_valid2, s_ready2, m_valid2, m_ready2, m_sat2, m_warm2;
  logic [1:0]         s_ch2, m_ch2, sat_sel2;
  logic signed [W-1:0] m_dT2;
  logic [2:0]         init2;
  logic [15:0]        sat_cnt2;

  dt_estimator_mc #(.N_CH(N_CH), .W(W), .FRAC(FRAC), .WARMUP(WARMUP)) u_dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_ch(s_ch),
    .s_T(s_T), .init_mask(init_mask), .alpha(alpha), .k_dt(k_dt), .d_max(d_max),
    .m_valid(m_valid), .m_ready(m_ready), .m_ch(m_ch), .m_dT(m_dT), .m_sat(m_sat),
    .m_warm(m_warm), .sat_sel(sat_sel), .sat_cnt(sat_cnt)
  );

  dt_estimator_mc #(.N_CH(3), .W(W), .FRAC(FRAC), .WARMUP(WARMUP)) u_small (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid2), .s_ready(s_ready2), .s_ch(s_ch2),
    .s_T(s_T), .init_mask(init2), .alpha(alpha), .k_dt(k_dt), .d_max(d_max),
    .m_valid(m_valid2), .m_ready(m_ready2), .m_ch(m_ch2), .m_dT(m_dT2), .m_sat(m_sat2),
    .m_warm(m_warm2), .sat_sel(sat_sel2), .sat_cnt(sat_cnt2)
  );

  typedef struct {
    int ch;
    int dt;
    bit sat;
    bit warm;
  } exp_t;

  exp_t q[$];
  int   vec = 0;
  int   err = 0;

  // Reference state per channel, kept in plain integers.
  int m_tprev [N_CH];
  int m_acc   [N_CH];
  bit m_primed[N_CH];
  int m_wcnt  [N_CH];
  int m_satc  [N_CH];

  task automatic check(input string name, input int act, input int exp);
    vec++;
    if (act != exp) begin
      err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push(input int ch, input int dt, input bit sat, input bit warm);
    exp_t e;
    e.ch = ch; e.dt = dt; e.sat = sat; e.warm = warm;
    q.push_back(e);
  endfunction

  function automatic void model_clear();
    for (int c = 0; c < N_CH; c++) begin
      m_tprev[c] = 0; m_acc[c] = 0; m_primed[c] = 1'b0; m_wcnt[c] = 0; m_satc[c] = 0;
    end
    q.delete();
  endfunction

  // One clock of the reference: init pulses and (if accepted) one sample.
  function automatic void model_step(input bit acc, input int ch, input int t,
                                     input logic [N_CH-1:0] init, input int a,
                                     input int k, input int dm);
    for (int c = 0; c < N_CH; c++) begin
      if (init[c]) begin
        m_acc[c] = 0; m_wcnt[c] = 0;
        if (acc && ch == c) begin
          m_tprev[c] = t; m_primed[c] = 1'b1;
          push(c, 0, 1'b0, 1'b0);
        end else begin
          m_primed[c] = 1'b0;
        end
      end else if (acc && ch == c) begin
        if (!m_primed[c]) begin
          m_tprev[c] = t; m_primed[c] = 1'b1; m_acc[c] = 0;
          push(c, 0, 1'b0, 1'b0);
        end else begin
          int kk, ds, nxt, lim;
          bit s;
          kk  = (k > FRAC) ? FRAC : k;
          ds  = ((t - m_tprev[c]) * (1 << FRAC)) >>> kk;
          nxt = (m_acc[c] * (256 - a) + ds * a) >>> 8;
          lim = dm * (1 << FRAC);
          s   = 1'b0;
          if (nxt > lim) begin nxt = lim; s = 1'b1; end
          else if (nxt < -lim) begin nxt = -lim; s = 1'b1; end
          m_acc[c]   = nxt;
          m_tprev[c] = t;
          if (m_wcnt[c] < WARMUP) m_wcnt[c]++;
          push(c, nxt / (1 << FRAC), s, m_wcnt[c] >= WARMUP);
          if (s && m_satc[c] < 65535) m_satc[c]++;
        end
      end
    end
  endfunction

  // Drive one cycle of inputs at the falling edge and advance the model.
  task automatic drive(input bit v, input int ch, input int t, input logic [N_CH-1:0] init,
                       input int a, input int k, input int dm, input bit mr);
    @(negedge clk);
    s_valid   = v;
    s_ch      = ch[CH_W-1:0];
    s_T       = t[W-1:0];
    init_mask = init;
    alpha     = a[7:0];
    k_dt      = k[3:0];
    d_max     = dm[W-2:0];
    m_ready   = mr;
    #1;
    model_step(v && s_ready, ch, t, init, a, k, dm);
  endtask

  // Replace the most recent expectation with a hand-derived value.
  task automatic set_last(input int dt, input bit sat, input bit warm);
    if (q.size() > 0) begin
      q[q.size()-1].dt   = dt;
      q[q.size()-1].sat  = sat;
      q[q.size()-1].warm = warm;
    end else begin
      vec++; err++;
      $display("FAIL set_last: got no pending result, expected one");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || m_valid) && n < 200) begin
      drive(1'b0, 0, 0, '0, 0, 0, 0, 1'b1);
      n++;
    end
    check("drain_timeout", n < 200, 1);
    check("queue_empty", q.size(), 0);
  endtask

  // Monitor: compare every presented result against the scoreboard head.
  always @(negedge clk) begin
    #2;
    if (rst_n && m_valid) begin
      if (q.size() == 0) begin
        vec++; err++;
        $display("FAIL unexpected_output: got ch=%0d dT=%0d, expected no result", m_ch, m_dT);
      end else begin
        check("m_ch",   int'(m_ch),   q[0].ch);
        check("m_dT",   int'(m_dT),   q[0].dt);
        check("m_sat",  int'(m_sat),  int'(q[0].sat));
        check("m_warm", int'(m_warm), int'(q[0].warm));
        if (m_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    s_valid = 1'b0; s_ch = '0; s_T = '0; init_mask = '0; alpha = '0; k_dt = '0;
    d_max = '0; m_ready = 1'b1; sat_sel = '0;
    s_valid2 = 1'b0; s_ch2 = '0; init2 = '0; m_ready2 = 1'b1; sat_sel2 = '0;
    model_clear();

    repeat (3) @(negedge clk);
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_m_ch",    int'(m_ch), 0);
    check("rst_m_dT",    int'(m_dT), 0);
    check("rst_m_sat",   int'(m_sat), 0);
    check("rst_m_warm",  int'(m_warm), 0);
    check("rst_sat_cnt", int'(sat_cnt), 0);
    rst_n = 1'b1;
    #1;
    check("s_ready_first_cycle", int'(s_ready), 0);
    @(negedge clk); #1;
    check("s_ready_after", int'(s_ready), 1);

    // ch0 ramp: 0,1,1,1 with warm 0,0,1,1
    drive(1'b0, 0, 0, 4'b0001, 128, 0, 127, 1'b1);
    drive(1'b1, 0, 10, '0, 128, 0, 127, 1'b1); set_last(0, 1'b0, 1'b0);
    drive(1'b1, 0, 12, '0, 128, 0, 127, 1'b1); set_last(1, 1'b0, 1'b0);
    drive(1'b1, 0, 14, '0, 128, 0, 127, 1'b1); set_last(1, 1'b0, 1'b1);
    drive(1'b1, 0, 16, '0, 128, 0, 127, 1'b1); set_last(1, 1'b0, 1'b1);

    // ch1 positive and negative clamps at d_max=20
    drive(1'b1, 1, 0,   4'b0010, 255, 0, 20, 1'b1); set_last(0, 1'b0, 1'b0);
    drive(1'b1, 1, 100, '0,      255, 0, 20, 1'b1); set_last(20, 1'b1, 1'b0);
    drive(1'b1, 1, 0,   4'b0010, 255, 0, 20, 1'b1); set_last(0, 1'b0, 1'b0);
    drive(1'b1, 1, -100, '0,     255, 0, 20, 1'b1); set_last(-20, 1'b1, 1'b0);

    // init and sample on ch2 in the same cycle
    drive(1'b1, 2, 50, 4'b0100, 255, 0, 127, 1'b1); set_last(0, 1'b0, 1'b0);
    drive(1'b1, 2, 52, '0,      255, 0, 127, 1'b1); set_last(1, 1'b0, 1'b0);
    drain();

    // ch0/ch2 interleave with m_ready toggling 1010
    for (int i = 0; i < 24; i++) begin
      drive(1'b1, (i % 2) ? 2 : 0, $signed(8'($urandom)), '0, 128, 1, 100, (i % 2) == 0);
    end
    drain();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [N_CH-1:0] im;
      im = '0;
      if ($urandom_range(0, 15) == 0) im = N_CH'($urandom);
      drive($urandom_range(0, 9) < 8, $urandom_range(0, N_CH-1), $signed(8'($urandom)), im,
            $urandom_range(0, 255), $urandom_range(0, 15), $urandom_range(0, 127),
            $urandom_range(0, 9) < 7);
    end
    drain();
    for (int c = 0; c < N_CH; c++) begin
      sat_sel = c[CH_W-1:0];
      #1;
`ifdef DT_EST_SAT_CNT_EN
      check("sat_cnt_random", int'(sat_cnt), m_satc[c]);
`else
      check("sat_cnt_random", int'(sat_cnt), 0);
`endif
    end

    // out-of-range channel on the 3-channel instance is accepted and dropped
    drive(1'b0, 0, 0, '0, 0, 0, 0, 1'b1);
    s_valid2 = 1'b1; s_ch2 = 2'd3;
    #1 check("oor_s_ready", int'(s_ready2), 1);
    drive(1'b0, 0, 0, '0, 0, 0, 0, 1'b1);
    s_valid2 = 1'b1; s_ch2 = 2'd1;
    #1 check("oor_no_m_valid", int'(m_valid2), 0);
    drive(1'b0, 0, 0, '0, 0, 0, 0, 1'b1);
    s_valid2 = 1'b0;
    #1 check("inrange_m_valid", int'(m_valid2), 1);
    check("inrange_m_ch", int'(m_ch2), 1);

    // asynchronous reset while a result is stalled
    drive(1'b1, 3, 5, '0, 100, 0, 127, 1'b0);
    drive(1'b0, 0, 0, '0, 100, 0, 127, 1'b0);
    check("held_before_reset", int'(m_valid), 1);
    #1 rst_n = 1'b0;
    #1 check("async_reset_m_valid", int'(m_valid), 0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 0, 0, '0, 0, 0, 0, 1'b1);

    // three clamped results on ch3
    drive(1'b1, 3, 0,    4'b1000, 255, 0, 20, 1'b1);
    drive(1'b1, 3, 100,  '0,      255, 0, 20, 1'b1); set_last(20, 1'b1, 1'b0);
    drive(1'b1, 3, -100, '0,      255, 0, 20, 1'b1); set_last(-20, 1'b1, 1'b1);
    drive(1'b1, 3, 100,  '0,      255, 0, 20, 1'b1); set_last(20, 1'b1, 1'b1);
    drain();
    sat_sel = 2'd3;
    #1;
`ifdef DT_EST_SAT_CNT_EN
    check("sat_cnt_ch3", int'(sat_cnt), 3);
`else
    check("sat_cnt_ch3", int'(sat_cnt), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
